// File: rtl/idli_pkg.sv
// Shared types for the idli core: SQI nibble/byte types, register selectors,
// the decoded operation record and the decoder state encoding.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;
  typedef logic [7:0] sqi_byte_t;
  typedef logic [2:0] greg_t;
  typedef logic [1:0] preg_t;
  typedef logic [2:0] fmt_t;

  localparam preg_t PREG_PT = 2'd3;

  localparam fmt_t FMT_ABC  = 3'd0;
  localparam fmt_t FMT_ABI  = 3'd1;
  localparam fmt_t FMT_AB   = 3'd2;
  localparam fmt_t FMT_A    = 3'd3;
  localparam fmt_t FMT_BC   = 3'd4;
  localparam fmt_t FMT_BI   = 3'd5;
  localparam fmt_t FMT_NOP  = 3'd6;
  localparam fmt_t FMT_RSVD = 3'd7;

  typedef logic [2:0] dec_state_t;
  localparam dec_state_t IHI = 3'd0;
  localparam dec_state_t ILO = 3'd1;
  localparam dec_state_t MHI = 3'd2;
  localparam dec_state_t MLO = 3'd3;
  localparam dec_state_t OUT = 3'd4;

  typedef struct packed {
    preg_t p;
    preg_t q;
    greg_t a;
    greg_t b;
    greg_t c;
    logic  a_vld;
    logic  b_vld;
    logic  c_vld;
    logic  imm;
  } op_t;

  localparam int OP_W = $bits(op_t);

  function automatic sqi_byte_t sqi_join(input sqi_data_t hi, input sqi_data_t lo);
    return {hi, lo};
  endfunction

  // Predicates default to "always true" so a reset op is a harmless no-op.
  function automatic op_t op_reset();
    op_t op;
    op   = '0;
    op.p = PREG_PT;
    op.q = PREG_PT;
    return op;
  endfunction

endpackage

// File: rtl/idli_decode_fmt.sv
// Combinational format decoder: maps the 3-bit fmt field to the operand-valid
// flags, the immediate flag and the reserved-format indication.
module idli_decode_fmt
  import idli_pkg::*;
(
  input  logic [2:0] fmt,
  output logic       a_vld,
  output logic       b_vld,
  output logic       c_vld,
  output logic       imm,
  output logic       illegal
);

  logic [4:0] flags_s;

  // Format table; an immediate always takes the c slot, so c_vld is 0 there.
  always_comb begin
    flags_s = 5'b00000;
    case (fmt)
      FMT_ABC:  flags_s = 5'b11100;
      FMT_ABI:  flags_s = 5'b11010;
      FMT_AB:   flags_s = 5'b11000;
      FMT_A:    flags_s = 5'b10000;
      FMT_BC:   flags_s = 5'b01100;
      FMT_BI:   flags_s = 5'b01010;
      FMT_NOP:  flags_s = 5'b00000;
      FMT_RSVD: flags_s = 5'b00001;
      default:  flags_s = 5'b00001;
    endcase
  end

  assign a_vld   = flags_s[4];
  assign b_vld   = flags_s[3];
  assign c_vld   = flags_s[2];
  assign imm     = flags_s[1];
  assign illegal = flags_s[0];

endmodule

// File: rtl/idli_decode.sv
// Nibble-pair instruction decoder: assembles a 16b instruction (high byte
// first) plus optional 16b immediate and hands a registered op to execute.
module idli_decode
  import idli_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_sqi_lo,
  input  logic [3:0]      i_sqi_hi,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic            i_flush,
  output logic [OP_W-1:0] o_op,
  output logic [15:0]     o_imm,
  output logic            o_illegal,
  output logic            o_vld,
  input  logic            i_rdy
);

  dec_state_t state_r, state_nxt_s;
  sqi_byte_t  ins_hi_r, ins_hi_nxt_s;
  logic [15:0] word_r, word_nxt_s;
  sqi_byte_t  imm_hi_r, imm_hi_nxt_s;
  op_t        op_r, op_nxt_s;
  logic [15:0] imm_r, imm_nxt_s;
  logic       ill_r, ill_nxt_s;
  logic       vld_r, vld_nxt_s;

  sqi_byte_t  byte_s;
  logic       rdy_s;
  logic       take_s;
  logic       done_s;
  logic [15:0] dec_word_s;
  op_t        dec_op_s;
  logic       f_a_vld_s, f_b_vld_s, f_c_vld_s, f_imm_s, f_ill_s;

  assign byte_s = sqi_join(i_sqi_hi, i_sqi_lo);

  // Ready: capture states always accept; OUT accepts only when its op drains.
  always_comb begin
    rdy_s = 1'b0;
    if (i_rst || i_flush) begin
      rdy_s = 1'b0;
    end else if (state_r == OUT) begin
      rdy_s = i_rdy;
    end else begin
      rdy_s = 1'b1;
    end
  end

  assign take_s = i_vld && rdy_s;
  assign done_s = vld_r && i_rdy;

  // The word is decoded as it completes in ILO, or from storage in MLO.
  assign dec_word_s = (state_r == ILO) ? {ins_hi_r, byte_s} : word_r;

  idli_decode_fmt u_fmt (
    .fmt     (dec_word_s[2:0]),
    .a_vld   (f_a_vld_s),
    .b_vld   (f_b_vld_s),
    .c_vld   (f_c_vld_s),
    .imm     (f_imm_s),
    .illegal (f_ill_s)
  );

  // Field extraction; c is passed through even when the slot holds an immediate.
  always_comb begin
    dec_op_s       = '0;
    dec_op_s.p     = dec_word_s[15:14];
    dec_op_s.q     = dec_word_s[13:12];
    dec_op_s.a     = dec_word_s[11:9];
    dec_op_s.b     = dec_word_s[8:6];
    dec_op_s.c     = dec_word_s[5:3];
    dec_op_s.a_vld = f_a_vld_s;
    dec_op_s.b_vld = f_b_vld_s;
    dec_op_s.c_vld = f_c_vld_s;
    dec_op_s.imm   = f_imm_s;
  end

  // Next-state and datapath update; flush overrides every capture or hold.
  always_comb begin
    state_nxt_s  = state_r;
    ins_hi_nxt_s = ins_hi_r;
    word_nxt_s   = word_r;
    imm_hi_nxt_s = imm_hi_r;
    op_nxt_s     = op_r;
    imm_nxt_s    = imm_r;
    ill_nxt_s    = ill_r;
    vld_nxt_s    = vld_r;
    if (i_flush) begin
      state_nxt_s = IHI;
      vld_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IHI: begin
          if (take_s) begin
            ins_hi_nxt_s = byte_s;
            state_nxt_s  = ILO;
          end else begin
            state_nxt_s = IHI;
          end
        end
        ILO: begin
          if (take_s && f_imm_s) begin
            word_nxt_s  = dec_word_s;
            state_nxt_s = MHI;
          end else if (take_s) begin
            op_nxt_s    = dec_op_s;
            imm_nxt_s   = 16'h0000;
            ill_nxt_s   = f_ill_s;
            vld_nxt_s   = 1'b1;
            state_nxt_s = OUT;
          end else begin
            state_nxt_s = ILO;
          end
        end
        MHI: begin
          if (take_s) begin
            imm_hi_nxt_s = byte_s;
            state_nxt_s  = MLO;
          end else begin
            state_nxt_s = MHI;
          end
        end
        MLO: begin
          if (take_s) begin
            op_nxt_s    = dec_op_s;
            imm_nxt_s   = {imm_hi_r, byte_s};
            ill_nxt_s   = f_ill_s;
            vld_nxt_s   = 1'b1;
            state_nxt_s = OUT;
          end else begin
            state_nxt_s = MLO;
          end
        end
        OUT: begin
          // A beat taken while draining is already the next high byte.
          if (done_s && take_s) begin
            ins_hi_nxt_s = byte_s;
            vld_nxt_s    = 1'b0;
            state_nxt_s  = ILO;
          end else if (done_s) begin
            vld_nxt_s   = 1'b0;
            state_nxt_s = IHI;
          end else begin
            state_nxt_s = OUT;
          end
        end
        default: begin
          vld_nxt_s   = 1'b0;
          state_nxt_s = IHI;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IHI;
      ins_hi_r <= 8'h00;
      word_r   <= 16'h0000;
      imm_hi_r <= 8'h00;
      op_r     <= op_reset();
      imm_r    <= 16'h0000;
      ill_r    <= 1'b0;
      vld_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ins_hi_r <= ins_hi_nxt_s;
      word_r   <= word_nxt_s;
      imm_hi_r <= imm_hi_nxt_s;
      op_r     <= op_nxt_s;
      imm_r    <= imm_nxt_s;
      ill_r    <= ill_nxt_s;
      vld_r    <= vld_nxt_s;
    end
  end

  assign o_rdy     = rdy_s;
  assign o_op      = op_r;
  assign o_imm     = imm_r;
  assign o_illegal = ill_r;
  assign o_vld     = vld_r;

endmodule

// File: tb/tb_idli_decode.sv
// Self-checking bench for idli_decode: directed scenarios plus random byte
// streams with random valid/ready/flush/reset against a transaction-level model.
module tb_idli_decode;
  import idli_pkg::*;

  logic            clk;
  logic            i_rst;
  logic [3:0]      i_sqi_lo;
  logic [3:0]      i_sqi_hi;
  logic            i_vld;
  logic            o_rdy;
  logic            i_flush;
  logic [OP_W-1:0] o_op;
  logic [15:0]     o_imm;
  logic            o_illegal;
  logic            o_vld;
  logic            i_rdy;

  idli_decode dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_sqi_lo  (i_sqi_lo),
    .i_sqi_hi  (i_sqi_hi),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_flush   (i_flush),
    .o_op      (o_op),
    .o_imm     (o_imm),
    .o_illegal (o_illegal),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the instruction in flight and the expected output.
  logic [7:0]  cur[$];
  logic        m_init  = 1'b0;
  logic        m_vld   = 1'b0;
  logic        m_known = 1'b0;
  op_t         m_op;
  logic [15:0] m_imm;
  logic        m_ill;

  // {a_vld, b_vld, c_vld, imm, illegal} straight from the format table.
  function automatic logic [4:0] spec_fmt(input logic [2:0] f);
    case (f)
      3'd0:    return 5'b11100;
      3'd1:    return 5'b11010;
      3'd2:    return 5'b11000;
      3'd3:    return 5'b10000;
      3'd4:    return 5'b01100;
      3'd5:    return 5'b01010;
      3'd6:    return 5'b00000;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic op_t mk_op(input logic [1:0] p, input logic [1:0] q, input logic [2:0] a,
                                input logic [2:0] b, input logic [2:0] c, input logic [3:0] v);
    op_t e;
    e.p = p; e.q = q; e.a = a; e.b = b; e.c = c;
    e.a_vld = v[3]; e.b_vld = v[2]; e.c_vld = v[1]; e.imm = v[0];
    return e;
  endfunction

  // One clock: drive at negedge, check just after, advance the model, wait a cycle.
  task automatic cycle(input logic rst, input logic flush, input logic vld,
                       input logic [7:0] b, input logic rdy);
    logic        exp_rdy;
    logic [15:0] w;
    logic [4:0]  f;
    i_rst    = rst;
    i_flush  = flush;
    i_vld    = vld;
    i_sqi_hi = b[7:4];
    i_sqi_lo = b[3:0];
    i_rdy    = rdy;
    #1;
    exp_rdy = !rst && !flush && (!m_vld || rdy);
    chk("o_rdy", o_rdy, exp_rdy);
    if (m_init) begin
      chk("o_vld", o_vld, m_vld);
      if (m_known) begin
        chk("o_op", o_op, m_op);
        chk("o_imm", o_imm, m_imm);
        chk("o_illegal", o_illegal, m_ill);
      end
    end
    if (rst) begin
      cur.delete();
      m_init = 1'b1; m_vld = 1'b0; m_known = 1'b1;
      m_op = mk_op(2'd3, 2'd3, 3'd0, 3'd0, 3'd0, 4'b0000);
      m_imm = 16'h0000; m_ill = 1'b0;
    end else if (flush) begin
      cur.delete();
      m_vld = 1'b0; m_known = 1'b0;
    end else begin
      if (m_vld && rdy) begin
        m_vld = 1'b0; m_known = 1'b0;
      end
      if (vld && exp_rdy) begin
        cur.push_back(b);
        if (cur.size() >= 2) begin
          w = {cur[0], cur[1]};
          f = spec_fmt(w[2:0]);
          if ((cur.size() == 2 && !f[1]) || cur.size() == 4) begin
            m_op  = mk_op(w[15:14], w[13:12], w[11:9], w[8:6], w[5:3], f[4:1]);
            m_imm = f[1] ? {cur[2], cur[3]} : 16'h0000;
            m_ill = f[0];
            m_vld = 1'b1; m_known = 1'b1;
            cur.delete();
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
    i_sqi_hi = 4'h0; i_sqi_lo = 4'h0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Plain op
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA8, 1'b1);
    chk("plain_vld", o_vld, 1'b1);
    chk("plain_op", o_op, mk_op(2'd3, 2'd2, 3'd2, 3'd2, 3'd5, 4'b1110));
    chk("plain_imm", o_imm, 16'h0000);
    chk("plain_ill", o_illegal, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Immediate op
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA9, 1'b1);
    chk("imm_no_early_vld", o_vld, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
    chk("imm_vld", o_vld, 1'b1);
    chk("imm_op", o_op, mk_op(2'd3, 2'd2, 3'd2, 3'd2, 3'd5, 4'b1101));
    chk("imm_val", o_imm, 16'h1234);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Illegal format
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
    chk("ill_flag", o_illegal, 1'b1);
    chk("ill_op", o_op, mk_op(2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 4'b0000));
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure then zero-bubble hand-over of 0x3C
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA8, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
    chk("b2b_no_vld", o_vld, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h06, 1'b1);
    chk("b2b_op", o_op, mk_op(2'd0, 2'd3, 3'd6, 3'd0, 3'd0, 4'b0000));
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Flush mid-immediate
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA9, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 8'h34, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h06, 1'b1);
    chk("flush_op", o_op, mk_op(2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 4'b0000));
    chk("flush_imm", o_imm, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-op
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'hA8, 1'b1);
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_op", o_op, mk_op(2'd3, 2'd3, 3'd0, 3'd0, 3'd0, 4'b0000));
    cycle(1'b0, 1'b0, 1'b1, 8'hE4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA8, 1'b1);
    chk("rst_after_op", o_op, mk_op(2'd3, 2'd2, 3'd2, 3'd2, 3'd5, 4'b1110));

    // Random streams
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_decode.md
Name: idli_decode

Overview:
Nibble-pair instruction decoder for the idli core. Consumes the byte stream delivered by the two SQI memories: SQI_MEM_LO supplies bits [3:0] and SQI_MEM_HI supplies bits [7:4] of each byte. Assembles each 16b instruction word, and its optional 16b immediate, then presents a registered op_t plus immediate to the execute stage over a valid/ready handshake.

Parameters:
None. All widths come from idli_pkg: sqi_data_t, greg_t, preg_t, op_t.

Ports:
- i_clk  in  1  core clock, single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_sqi_lo  in  4  low nibble of current byte (sqi_data_t, from SQI_MEM_LO)
- i_sqi_hi  in  4  high nibble of current byte (sqi_data_t, from SQI_MEM_HI)
- i_vld  in  1  byte on i_sqi_lo/hi is valid
- o_rdy  out  1  decoder accepts byte this cycle; beat is taken when i_vld && o_rdy
- i_flush  in  1  discard any partial or held instruction (redirect)
- o_op  out  $bits(op_t)  decoded operation
- o_imm  out  16  immediate; meaningful only when o_op.imm = 1
- o_illegal  out  1  reserved format decoded; qualified by o_vld
- o_vld  out  1  o_op, o_imm and o_illegal are valid
- i_rdy  in  1  execute accepts output; handshake completes when o_vld && i_rdy

Behaviour:
- Byte order: first beat is the high byte, second beat is the low byte. This applies to both the instruction word and the immediate.
- Instruction word fields:
  - [15:14] p, [13:12] q
  - [11:9] a, [8:6] b, [5:3] c
  - [2:0] fmt
- fmt decode, giving {a_vld, b_vld, c_vld, imm}:
  - 0: 1110
  - 1: 1101
  - 2: 1100
  - 3: 1000
  - 4: 0110
  - 5: 0101
  - 6: 0000
  - 7: reserved. Decodes as 0000 and sets o_illegal = 1.
- imm = 1 forces c_vld = 0. The c field is still passed through unchanged.
- FSM states:
  - IHI: wait for the first instruction byte
  - ILO: wait for the second instruction byte
  - MHI: wait for the immediate high byte
  - MLO: wait for the immediate low byte
  - OUT: holding output
- Transitions, each on an accepted beat:
  - IHI -> ILO
  - ILO -> MHI if fmt decodes imm = 1, otherwise -> OUT
  - MHI -> MLO
  - MLO -> OUT
- OUT exit:
  - o_vld && i_rdy with no beat accepted -> IHI.
  - o_vld && i_rdy with a beat accepted in the same cycle -> ILO; that beat is the next instruction's high byte.
- o_rdy:
  - 1 in IHI, ILO, MHI, MLO.
  - In OUT, o_rdy = i_rdy (zero-bubble back-to-back).
  - Forced to 0 while i_flush = 1.
- Latency: o_vld rises the cycle after the final beat is accepted. Throughput is 2 beats per instruction without an immediate and 4 beats with one.
- While o_vld && !i_rdy, o_op, o_imm and o_illegal hold stable.
- o_imm is zeroed when a non-imm instruction is loaded into OUT.
- i_flush:
  - Priority is below i_rst and above everything else.
  - Next state is IHI and o_vld is 0 next cycle.
  - Any partially assembled word or immediate is dropped.
  - No beat is accepted in the flush cycle.
  - A held output is discarded even if i_rdy = 1 in the same cycle; execute must ignore that handshake.
- Reset, including mid-instruction:
  - state = IHI, o_vld = 0, o_illegal = 0, o_imm = 0
  - o_op = 0 except o_op.p = PREG_PT and o_op.q = PREG_PT
  - o_rdy = 0 during the reset cycle
- i_vld = 0 in any capture state: hold the state and partial data indefinitely.

Decomposition:
- idli_pkg additions:
  - typedef logic [2:0] fmt_t and enum constants FMT_ABC, FMT_ABI, FMT_AB, FMT_A, FMT_BC, FMT_BI, FMT_NOP, FMT_RSVD
  - typedef logic [7:0] sqi_byte_t
  - dec_state_t enum {IHI, ILO, MHI, MLO, OUT}
- Sub-module idli_decode_fmt: purely combinational. Maps fmt_t to {a_vld, b_vld, c_vld, imm, illegal}. Reused by the disassembler and bench model.

Test Plan:
- Plain op: beats 0xE4 then 0xA8, i_rdy = 1. Expected one cycle after the second beat: o_vld = 1, p = 3, q = 2, a = 2, b = 2, c = 5, vld bits 1110, imm = 0, o_illegal = 0, o_imm = 0x0000.
- Immediate op: beats 0xE4, 0xA9, 0x12, 0x34. Expected: o_vld after the 4th beat, imm = 1, c_vld = 0, c = 5, o_imm = 0x1234. No o_vld after beat 2.
- Illegal format: beats 0x00, 0x07. Expected: o_vld = 1, o_illegal = 1, all vld bits 0, p = 0, q = 0.
- Backpressure and back-to-back:
  - Hold i_rdy = 0 for 3 cycles after o_vld with i_vld = 1 and the next byte 0x3C presented. Expected: o_rdy = 0, outputs stable.
  - Then raise i_rdy. Expected: 0x3C is consumed in the same cycle and state -> ILO.
- Flush mid-immediate: after beats 0xE4, 0xA9, 0x12, assert i_flush for 1 cycle, then send 0x00, 0x06. Expected: a single output with vld bits 0000, o_imm = 0; 0x12 never appears.
- Reset mid-op: assert i_rst after the first byte. Expected: o_vld = 0 and o_op.p = o_op.q = 3 next cycle; a following 2-beat instruction decodes correctly.
